// File: rtl/cart_rom_reader.sv
// Cartridge ROM read responder: turns mapper reads into SDRAM fetches, stalls the Z80 via WAIT until data arrives.
// Optional single-entry read cache compiled in with `define CART_READ_CACHE_EN.
module cart_rom_reader #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        mem_oe,
  input  logic [24:0] mem_addr,
  input  logic [24:0] rom_size,
  input  logic        inval,
  output logic [7:0]  d_to_cpu,
  output logic        wait_n,
  output logic [24:0] ram_addr,
  output logic        ram_req,
  input  logic        ram_ack,
  input  logic [7:0]  ram_din
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic        rd_oe, rd_oe_q, start, oor, hit;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  dout_q, dout_d;
  logic [24:0] addr_q, addr_d;
  logic        req_q, req_d;

`ifdef CART_READ_CACHE_EN
  logic        valid_q, valid_d;
  logic [24:0] tag_q, tag_d;
  logic [7:0]  cdata_q, cdata_d;

  assign hit = valid_q && (tag_q == mem_addr);
`else
  logic unused_inval;

  assign unused_inval = inval;
  assign hit          = 1'b0;
`endif

  assign rd_oe = rd & mem_oe;
  assign start = rd_oe & ~rd_oe_q;
  assign oor   = (mem_addr >= rom_size);

  // WAIT drops combinationally in the start cycle so the Z80 never samples it high on a miss.
  assign wait_n = ~((state_q == REQ) | ((state_q == IDLE) & start & ~oor & ~hit));

  assign d_to_cpu = dout_q;
  assign ram_addr = addr_q;
  assign ram_req  = req_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    addr_d  = addr_q;
    req_d   = req_q;
`ifdef CART_READ_CACHE_EN
    valid_d = valid_q;
    tag_d   = tag_q;
    cdata_d = cdata_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (oor) begin
            dout_d  = 8'hFF;
            state_d = HOLD;
          end else if (hit) begin
`ifdef CART_READ_CACHE_EN
            dout_d  = cdata_q;
`endif
            state_d = HOLD;
          end else begin
            addr_d  = mem_addr;
            req_d   = 1'b1;
            cnt_d   = 8'd0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (ram_ack) begin
          dout_d  = ram_din;
          req_d   = 1'b0;
          state_d = HOLD;
`ifdef CART_READ_CACHE_EN
          valid_d = 1'b1;
          tag_d   = addr_q;
          cdata_d = ram_din;
`endif
        end else if (cnt_q == TIMEOUT_CNT) begin
          dout_d  = 8'hFF;
          req_d   = 1'b0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (!rd_oe) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef CART_READ_CACHE_EN
    // Invalidate has priority over a refill landing in the same cycle.
    if (inval) valid_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rd_oe_q <= 1'b0;
      cnt_q   <= 8'd0;
      dout_q  <= 8'hFF;
      addr_q  <= 25'd0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_oe_q <= rd_oe;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

`ifdef CART_READ_CACHE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= 25'd0;
      cdata_q <= 8'd0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      cdata_q <= cdata_d;
    end
  end
`endif

endmodule
